// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one-outstanding-request bus master feeding the fetch stage.
// Build option: define IFETCH_MISALIGN_EN to raise out_excp on misaligned redirect targets.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_excp
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0] r_ireq_addr, w_ireq_addr_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic [31:0] r_out_pc, w_out_pc_nxt;
  logic [31:0] r_out_instr, w_out_instr_nxt;
  logic        r_out_excp, w_out_excp_nxt;
  logic [31:0] r_hold_data, w_hold_data_nxt;
  logic        r_hold_full, w_hold_full_nxt;
  logic        r_drop_pend, w_drop_pend_nxt;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_go_pc;
  logic        w_go_req;

`ifdef IFETCH_MISALIGN_EN
  assign w_redirect_pc = redirect_pc;
  assign out_excp      = r_out_excp;
`else
  logic w_unused;
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign out_excp      = 1'b0;
  assign w_unused      = ^{redirect_pc[1:0], r_out_excp};
`endif

  assign w_pc_plus4 = r_fetch_pc + 32'd4;
  assign ireq_valid = (r_state == REQ);
  assign ireq_addr  = r_ireq_addr;
  assign out_valid  = r_out_valid;
  assign out_pc     = r_out_pc;
  assign out_instr  = r_out_instr;

  always_comb begin
    // NOTE: every next-value gets a default first so no path through this block infers a latch.
    w_state_nxt     = r_state;
    w_fetch_pc_nxt  = r_fetch_pc;
    w_ireq_addr_nxt = r_ireq_addr;
    w_out_valid_nxt = r_out_valid;
    w_out_pc_nxt    = r_out_pc;
    w_out_instr_nxt = r_out_instr;
    w_out_excp_nxt  = r_out_excp;
    w_hold_data_nxt = r_hold_data;
    w_hold_full_nxt = r_hold_full;
    w_drop_pend_nxt = r_drop_pend;
    w_go_req        = 1'b0;
    w_go_pc         = r_fetch_pc;

    if (r_out_valid && !stall) begin
      w_out_valid_nxt = 1'b0;
      w_out_excp_nxt  = 1'b0;
    end
    // A taken branch kills whatever is presented or held, even under stall.
    if (redirect_valid) begin
      w_out_valid_nxt = 1'b0;
      w_out_excp_nxt  = 1'b0;
      w_hold_full_nxt = 1'b0;
      w_fetch_pc_nxt  = w_redirect_pc;
    end

    case (r_state)
      IDLE: begin
        w_go_req = 1'b1;
        w_go_pc  = w_fetch_pc_nxt;
      end
      REQ: begin
        if (redirect_valid) w_drop_pend_nxt = 1'b1;
        if (ireq_addr_ok) begin
          w_state_nxt     = (redirect_valid || r_drop_pend) ? DROP : WAIT;
          w_drop_pend_nxt = 1'b0;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          // A response landing on the redirect edge is already stale; nothing left to drop.
          if (iresp_data_ok) begin
            w_go_req = 1'b1;
            w_go_pc  = w_redirect_pc;
          end else begin
            w_state_nxt = DROP;
          end
        end else if (iresp_data_ok) begin
          if (!r_out_valid || !stall) begin
            w_out_valid_nxt = 1'b1;
            w_out_pc_nxt    = r_fetch_pc;
            w_out_instr_nxt = iresp_data;
            w_out_excp_nxt  = 1'b0;
            w_fetch_pc_nxt  = w_pc_plus4;
            w_go_req        = 1'b1;
            w_go_pc         = w_pc_plus4;
          end else begin
            w_hold_data_nxt = iresp_data;
            w_hold_full_nxt = 1'b1;
            w_state_nxt     = HOLD;
          end
        end
      end
      DROP: begin
        if (iresp_data_ok) begin
          w_go_req = 1'b1;
          w_go_pc  = w_fetch_pc_nxt;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_go_req = 1'b1;
          w_go_pc  = w_redirect_pc;
        end else if (!stall && r_hold_full) begin
          w_out_valid_nxt = 1'b1;
          w_out_pc_nxt    = r_fetch_pc;
          w_out_instr_nxt = r_hold_data;
          w_out_excp_nxt  = 1'b0;
          w_hold_full_nxt = 1'b0;
          w_fetch_pc_nxt  = w_pc_plus4;
          w_go_req        = 1'b1;
          w_go_pc         = w_pc_plus4;
        end
        // An empty HOLD is a consumed address error parked until the next redirect.
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_go_req) begin
      w_state_nxt     = REQ;
      w_ireq_addr_nxt = w_go_pc;
`ifdef IFETCH_MISALIGN_EN
      if (w_go_pc[1:0] != 2'b00) begin
        w_state_nxt     = HOLD;
        w_ireq_addr_nxt = r_ireq_addr;
        w_out_valid_nxt = 1'b1;
        w_out_excp_nxt  = 1'b1;
        w_out_pc_nxt    = w_go_pc;
        w_out_instr_nxt = 32'd0;
        w_hold_full_nxt = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_fetch_pc  <= RESET_PC;
      r_ireq_addr <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_pc    <= 32'd0;
      r_out_instr <= 32'd0;
      r_out_excp  <= 1'b0;
      r_hold_data <= 32'd0;
      r_hold_full <= 1'b0;
      r_drop_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_ireq_addr <= w_ireq_addr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_out_excp  <= w_out_excp_nxt;
      r_hold_data <= w_hold_data_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_drop_pend <= w_drop_pend_nxt;
    end
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc0_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  decode stage cannot accept; hold output.
REQ-005 redirect_valid  input  1  one-cycle branch/jump taken pulse.
REQ-006 redirect_pc  input  32  target address for redirect.
REQ-007 ireq_valid  output  1  instruction bus request.
REQ-008 ireq_addr  output  32  request address.
REQ-009 ireq_addr_ok  input  1  bus accepts request this cycle.
REQ-010 iresp_data_ok  input  1  response data valid this cycle.
REQ-011 iresp_data  input  32  fetched instruction word.
REQ-012 out_valid  output  1  out_pc/out_instr valid for fetch stage.
REQ-013 out_pc  output  32  address of out_instr.
REQ-014 out_instr  output  32  instruction word to fetch stage.
REQ-015 out_excp  output  1  address-error flag for out_pc.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, DROP, HOLD.
REQ-017 IDLE SHALL last exactly one cycle after reset deassertion, then go to REQ with ireq_addr=fetch_pc.
REQ-018 In REQ, ireq_valid=1; ireq_addr SHALL stay stable until ireq_addr_ok=1; on ireq_addr_ok go to WAIT (no redirect) or DROP (redirect seen during or at this request).
REQ-019 iresp_data_ok SHALL be honoured only in WAIT/DROP; responses arrive at least 1 cycle after ireq_addr_ok, at most one outstanding request.
REQ-020 WAIT + data_ok + (out_valid=0 or stall=0): load out_valid=1, out_pc=fetch_pc, out_instr=iresp_data; fetch_pc+=4 (mod 2^32 wrap); go REQ next cycle.
REQ-021 WAIT + data_ok + out_valid=1 + stall=1: capture word in hold buffer, go HOLD; in HOLD when stall=0, move buffer to output, fetch_pc+=4, go REQ.
REQ-022 Outputs SHALL stay constant while out_valid=1 and stall=1; out_valid cleared when consumed (stall=0) with nothing new to load.
REQ-023 redirect_valid SHALL override stall: same edge clears out_valid and any held word, fetch_pc<=redirect_pc.
REQ-024 Redirect in WAIT -> DROP; in DROP the pending response is discarded, then REQ with new fetch_pc; further redirects in DROP only update fetch_pc.
REQ-025 Redirect in REQ SHALL NOT change ireq_addr; request completes, then DROP.
REQ-026 Redirect in HOLD or IDLE -> REQ next cycle with redirect_pc.
REQ-027 Steady state throughput: one instruction per 2 cycles minimum (REQ, WAIT) with zero-wait bus.

Reset
REQ-028 On reset: state=IDLE, fetch_pc=RESET_PC, ireq_valid=0, ireq_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0, out_excp=0, hold buffer empty.
REQ-029 Reset mid-request SHALL abandon the in-flight transaction; bus must tolerate a dropped response.

Configuration
REQ-030 Macro IFETCH_MISALIGN_EN defined: redirect_pc[1:0]!=0 produces no bus request; next cycle out_valid=1, out_excp=1, out_pc=redirect_pc, out_instr=0, state HOLD until consumed or redirected.
REQ-031 Macro undefined: redirect_pc[1:0] forced to 2'b00, out_excp tied 0.

Verification
REQ-032 Reset release, zero-wait bus returning 32'h2408_0001 -> first out_valid with out_pc=32'hbfc0_0000, out_instr=32'h2408_0001, then out_pc 32'hbfc0_0004.
REQ-033 stall held 5 cycles with data_ok arriving -> outputs constant, state HOLD, no new request; release -> next word out, no loss/duplication.
REQ-034 redirect_valid to 32'h8000_0100 during WAIT -> stale response dropped, next out_pc=32'h8000_0100.
REQ-035 redirect while ireq_addr_ok low in REQ -> ireq_addr unchanged until accepted, response discarded, then request at target.
REQ-036 fetch_pc=32'hffff_fffc consumed -> next ireq_addr=32'h0000_0000.
REQ-037 IFETCH_MISALIGN_EN set, redirect_pc=32'h8000_0102 -> out_excp=1, out_pc=32'h8000_0102, ireq_valid stays 0.
